// File: rtl/dm_cache_ctrl_pkg.sv
// Shared types for the direct-mapped write-back cache: CPU, memory and
// tag/data store interfaces, address field positions and controller states.
package cache_def;

  localparam int TAGMSB = 31;
  localparam int TAGLSB = 14;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE_TAG,
    ALLOCATE,
    WRITE_BACK
  } cache_state_type;

  typedef struct packed {
    logic                valid;
    logic                dirty;
    logic [TAGMSB:TAGLSB] tag;
  } cache_tag_type;

  typedef struct packed {
    logic [9:0] index;
    logic       we;
  } cache_req_type;

  typedef logic [127:0] cache_data_type;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
    logic        valid;
  } cpu_req_type;

  typedef struct packed {
    logic [31:0] data;
    logic        ready;
  } cpu_result_type;

  typedef struct packed {
    logic [31:0]    addr;
    cache_data_type data;
    logic           rw;
    logic           valid;
  } mem_req_type;

  typedef struct packed {
    cache_data_type data;
    logic           ready;
  } mem_data_type;

endpackage

// File: rtl/dm_cache_word_merge.sv
// Combinational 32-bit word select and insert within a 128-bit cache block.
module dm_cache_word_merge
  import cache_def::*;
(
  input  cache_data_type blk,
  input  logic [1:0]     word_sel,
  input  logic [31:0]    wdata,
  output cache_data_type merged,
  output logic [31:0]    rdata
);

  // Read the addressed word and build the block with that word replaced.
  always_comb begin
    merged = blk;
    merged[{word_sel, 5'b0} +: 32] = wdata;
    rdata = blk[{word_sel, 5'b0} +: 32];
  end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Controller for a direct-mapped write-back, write-allocate cache.
// Only the state and the latched CPU request are registered; every store
// command and handshake output is decoded from them each cycle, so the
// tag/data stores (combinational read, posedge write) see the same cycle.
module dm_cache_ctrl
  import cache_def::*;
#(
  parameter int IDX_W = 10,
  parameter int TAG_W = 18
) (
  input  logic           clk,
  input  logic           rst_n,
  input  cpu_req_type    cpu_req,
  output cpu_result_type cpu_res,
  input  mem_data_type   mem_data,
  output mem_req_type    mem_req,
  output cache_req_type  tag_req,
  output cache_tag_type  tag_write,
  input  cache_tag_type  tag_read,
  output cache_req_type  data_req,
  output cache_data_type data_write,
  input  cache_data_type data_read
);

  cache_state_type state, state_d;
  cpu_req_type     req_q, req_d;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic             hit;
  cache_data_type   merged_blk;
  logic [31:0]      rd_word;

  assign req_tag = req_q.addr[31 -: TAG_W];
  assign req_idx = req_q.addr[4 +: IDX_W];
  assign hit     = tag_read.valid && (tag_read.tag == req_tag);

  dm_cache_word_merge u_merge (
    .blk      (data_read),
    .word_sel (req_q.addr[3:2]),
    .wdata    (req_q.data),
    .merged   (merged_blk),
    .rdata    (rd_word)
  );

  // Next-state and output decode; store writes are suppressed while reset
  // is asserted so an aborted refill or write hit never lands in the stores.
  always_comb begin
    state_d = state;
    req_d   = req_q;

    tag_req.index  = req_idx;
    tag_req.we     = 1'b0;
    tag_write      = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
    data_req.index = req_idx;
    data_req.we    = 1'b0;
    data_write     = data_read;

    mem_req.addr  = {req_tag, req_idx, 4'b0};
    mem_req.data  = data_read;
    mem_req.rw    = 1'b0;
    mem_req.valid = 1'b0;

    cpu_res.data  = rd_word;
    cpu_res.ready = 1'b0;

    case (state)
      IDLE: begin
        if (cpu_req.valid) begin
          req_d   = cpu_req;
          state_d = COMPARE_TAG;
        end
      end
      COMPARE_TAG: begin
        if (hit) begin
          cpu_res.ready = 1'b1;
          if (req_q.rw) begin
            data_req.we     = 1'b1;
            data_write      = merged_blk;
            tag_req.we      = 1'b1;
            tag_write.dirty = 1'b1;
          end
          state_d = IDLE;
        end else if (tag_read.valid && tag_read.dirty) begin
          state_d = WRITE_BACK;
        end else begin
          state_d = ALLOCATE;
        end
      end
      WRITE_BACK: begin
        mem_req.addr  = {tag_read.tag, req_idx, 4'b0};
        mem_req.rw    = 1'b1;
        mem_req.valid = 1'b1;
        if (mem_data.ready) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        mem_req.valid = 1'b1;
        if (mem_data.ready) begin
          data_req.we = 1'b1;
          data_write  = mem_data.data;
          tag_req.we  = 1'b1;
          state_d     = COMPARE_TAG;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!rst_n) begin
      tag_req.we    = 1'b0;
      data_req.we   = 1'b0;
      cpu_res.ready = 1'b0;
    end
  end

  // State and latched request; reset returns to IDLE with an empty request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      req_q <= '0;
    end else begin
      state <= state_d;
      req_q <= req_d;
    end
  end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl with behavioural tag/data stores and a
// hand-driven memory port.
module tb_dm_cache_ctrl;
  import cache_def::*;

  logic           clk = 1'b0;
  logic           rst_n;
  cpu_req_type    cpu_req;
  cpu_result_type cpu_res;
  mem_data_type   mem_data;
  mem_req_type    mem_req;
  cache_req_type  tag_req, data_req;
  cache_tag_type  tag_write, tag_read;
  cache_data_type data_write, data_read;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc      = 0;

  localparam logic [127:0] BLK1  = 128'h0000_4444_0000_3333_0000_2222_0000_1111;
  localparam logic [127:0] BLK1W = 128'h0000_4444_DEAD_BEEF_0000_2222_0000_1111;
  localparam logic [127:0] BLK2  = 128'h0000_BBB3_0000_BBB2_0000_BBB1_0000_BBB0;
  localparam logic [127:0] BLK3  = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;

  cache_tag_type  tag_mem  [1024] = '{default: '0};
  cache_data_type data_mem [1024] = '{default: '0};

  always #5 clk = ~clk;

  dm_cache_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_res    (cpu_res),
    .mem_data   (mem_data),
    .mem_req    (mem_req),
    .tag_req    (tag_req),
    .tag_write  (tag_write),
    .tag_read   (tag_read),
    .data_req   (data_req),
    .data_write (data_write),
    .data_read  (data_read)
  );

  assign tag_read  = tag_mem[tag_req.index];
  assign data_read = data_mem[data_req.index];

  always @(posedge clk) begin
    if (tag_req.we)  tag_mem[tag_req.index]   <= tag_write;
    if (data_req.we) data_mem[data_req.index] <= data_write;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic set_req(input logic [31:0] a, input logic [31:0] d, input logic rw, input logic v);
    cpu_req = '{addr: a, data: d, rw: rw, valid: v};
  endtask

  initial begin
    rst_n    = 1'b0;
    cpu_req  = '0;
    mem_data = '0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_ready", cpu_res.ready, 0);
    check("rst_memv", mem_req.valid, 0);
    check("rst_tagwe", tag_req.we, 0);
    check("rst_datawe", data_req.we, 0);

    // cold read miss at 0x4010, memory answers on the third allocate cycle
    set_req(32'h4010, 32'h0, 1'b0, 1'b1);
    acc = cyc;
    tick();
    check("miss_cmp_ready", cpu_res.ready, 0);
    check("miss_cmp_memv", mem_req.valid, 0);
    tick();
    check("alloc_valid", mem_req.valid, 1);
    check("alloc_addr", mem_req.addr, 32'h4010);
    check("alloc_rw", mem_req.rw, 0);
    tick();
    tick();
    mem_data = '{data: BLK1, ready: 1'b1};
    #1;
    check("refill_datawe", data_req.we, 1);
    check("refill_data", data_write, BLK1);
    check("refill_tagwe", tag_req.we, 1);
    check("refill_tag", tag_write, {1'b1, 1'b0, 18'h1});
    tick();
    mem_data.ready = 1'b0;
    #1;
    check("miss_ready", cpu_res.ready, 1);
    check("miss_data", cpu_res.data, 32'h0000_1111);
    check("miss_latency", cyc - acc, 5);
    check("tag1_after_refill", tag_mem[1], {1'b1, 1'b0, 18'h1});
    cpu_req.valid = 1'b0;
    tick();

    // read hit word 1
    set_req(32'h4014, 32'h0, 1'b0, 1'b1);
    tick();
    check("hit_ready", cpu_res.ready, 1);
    check("hit_data", cpu_res.data, 32'h0000_2222);
    check("hit_memv", mem_req.valid, 0);
    cpu_req.valid = 1'b0;
    tick();

    // write hit word 2
    set_req(32'h4018, 32'hDEAD_BEEF, 1'b1, 1'b1);
    tick();
    check("wr_ready", cpu_res.ready, 1);
    check("wr_datawe", data_req.we, 1);
    check("wr_merge", data_write, BLK1W);
    check("wr_tag", tag_write, {1'b1, 1'b1, 18'h1});
    cpu_req.valid = 1'b0;
    tick();
    check("tag1_dirty", tag_mem[1].dirty, 1);
    set_req(32'h4018, 32'h0, 1'b0, 1'b1);
    tick();
    check("rd_after_wr_ready", cpu_res.ready, 1);
    check("rd_after_wr_data", cpu_res.data, 32'hDEAD_BEEF);
    cpu_req.valid = 1'b0;
    tick();

    // dirty conflict read of 0x8010: write back then refill
    set_req(32'h8010, 32'h0, 1'b0, 1'b1);
    tick();
    check("conf_cmp_ready", cpu_res.ready, 0);
    tick();
    check("wb_valid", mem_req.valid, 1);
    check("wb_rw", mem_req.rw, 1);
    check("wb_addr", mem_req.addr, 32'h4010);
    check("wb_data", mem_req.data, BLK1W);
    check("wb_tagwe", tag_req.we, 0);
    tick();
    check("wb_hold_valid", mem_req.valid, 1);
    check("wb_hold_addr", mem_req.addr, 32'h4010);
    mem_data = '{data: '0, ready: 1'b1};
    tick();
    mem_data.ready = 1'b0;
    #1;
    check("conf_alloc_valid", mem_req.valid, 1);
    check("conf_alloc_addr", mem_req.addr, 32'h8010);
    check("conf_alloc_rw", mem_req.rw, 0);
    mem_data = '{data: BLK2, ready: 1'b1};
    #1;
    check("conf_refill_tag", tag_write, {1'b1, 1'b0, 18'h2});
    tick();
    mem_data.ready = 1'b0;
    #1;
    check("conf_ready", cpu_res.ready, 1);
    check("conf_data", cpu_res.data, 32'h0000_BBB0);
    cpu_req.valid = 1'b0;
    tick();
    check("tag1_after_conf", tag_mem[1], {1'b1, 1'b0, 18'h2});

    // reset while waiting in ALLOCATE for 0xC010
    set_req(32'hC010, 32'h0, 1'b0, 1'b1);
    tick();
    tick();
    check("rst_alloc_valid", mem_req.valid, 1);
    rst_n         = 1'b0;
    cpu_req.valid = 1'b0;
    mem_data      = '{data: BLK3, ready: 1'b1};
    #1;
    check("rst_cycle_tagwe", tag_req.we, 0);
    check("rst_cycle_datawe", data_req.we, 0);
    tick();
    rst_n          = 1'b1;
    mem_data.ready = 1'b0;
    #1;
    check("post_rst_memv", mem_req.valid, 0);
    check("post_rst_ready", cpu_res.ready, 0);
    check("post_rst_tag1", tag_mem[1], {1'b1, 1'b0, 18'h2});
    check("post_rst_data1", data_mem[1], BLK2);
    set_req(32'h8014, 32'h0, 1'b0, 1'b1);
    tick();
    check("fresh_ready", cpu_res.ready, 1);
    check("fresh_data", cpu_res.data, 32'h0000_BBB1);
    cpu_req.valid = 1'b0;
    tick();

    // stray memory ready while idle
    mem_data = '{data: BLK3, ready: 1'b1};
    tick();
    tick();
    check("stray_memv", mem_req.valid, 0);
    check("stray_tagwe", tag_req.we, 0);
    check("stray_datawe", data_req.we, 0);
    check("stray_ready", cpu_res.ready, 0);
    mem_data.ready = 1'b0;

    // valid held after ready is taken as a second request
    set_req(32'h8018, 32'h0, 1'b0, 1'b1);
    tick();
    check("held1_ready", cpu_res.ready, 1);
    check("held1_data", cpu_res.data, 32'h0000_BBB2);
    tick();
    check("held_idle_ready", cpu_res.ready, 0);
    tick();
    check("held2_ready", cpu_res.ready, 1);
    check("held2_memv", mem_req.valid, 0);
    cpu_req.valid = 1'b0;
    tick();
    check("end_ready", cpu_res.ready, 0);
    check("end_tag1", tag_mem[1], {1'b1, 1'b0, 18'h2});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
Controller FSM for the direct-mapped write-back, write-allocate cache: 1024 lines, 128-bit blocks, 32-bit addresses.
- Accepts CPU requests and looks up the tag and data stores, which it drives through cache_req_type commands.
- Returns hit data to the CPU.
- On a miss it writes back a dirty victim, then refills the line from main memory.
- Sits directly upstream of the tag store and the data store, and between the CPU port and the memory port.

Parameters:
IDX_W, 10, index width (1024 lines); must match the tag/data store depth
TAG_W, 18, tag width; TAG_W + IDX_W + 4 = 32

Ports:
clk  in  1  single clock; all state updates on posedge
rst_n  in  1  synchronous active-low reset
cpu_req  in  cpu_req_type  {addr[31:0], data[31:0], rw (1=write), valid}
cpu_res  out  cpu_result_type  {data[31:0], ready}
mem_data  in  mem_data_type  {data[127:0], ready}: memory response
mem_req  out  mem_req_type  {addr[31:0], data[127:0], rw, valid}: memory request
tag_req  out  cache_req_type  {index[9:0], we}: tag store command
tag_write  out  cache_tag_type  {valid, dirty, tag[17:0]}: tag store write data
tag_read  in  cache_tag_type  combinational tag store read at tag_req.index
data_req  out  cache_req_type  data store command
data_write  out  cache_data_type  128-bit block write data
data_read  in  cache_data_type  combinational data store read

Behaviour:
- Address split: tag = addr[31:14], index = addr[13:4], word = addr[3:2]. addr[1:0] is ignored.
- States: IDLE, COMPARE_TAG, WRITE_BACK, ALLOCATE. State register and latched request (req_q) are the only flops.
- Reset (rst_n=0 at posedge):
  - state <= IDLE, req_q <= 0.
  - All outputs are then 0: cpu_res.ready=0, mem_req.valid=0, tag_req.we=0, data_req.we=0.
  - Reset mid-operation aborts the operation: mem_req.valid drops the next cycle and no store write is issued.
- Default every cycle: all we=0, mem_req.valid=0, cpu_res.ready=0.
  - tag_req.index and data_req.index = req_q index.
  - cpu_res.data = data_read word selected by req_q.addr[3:2].
- IDLE: if cpu_req.valid, then req_q <= cpu_req and go to COMPARE_TAG. Otherwise stay.
- COMPARE_TAG: hit = tag_read.valid && tag_read.tag == req_q tag.
  - Hit, read: cpu_res.ready=1 for 1 cycle, go to IDLE.
  - Hit, write:
    - cpu_res.ready=1.
    - data_req.we=1; data_write = data_read with word[addr[3:2]] replaced by req_q.data.
    - tag_req.we=1; tag_write = {1,1,tag}.
    - Go to IDLE.
  - Miss with victim valid && dirty: go to WRITE_BACK.
  - Miss otherwise: go to ALLOCATE.
- WRITE_BACK:
  - mem_req = {addr={tag_read.tag, index, 4'b0}, data=data_read, rw=1, valid=1}.
  - Hold until mem_data.ready=1, then go to ALLOCATE.
- ALLOCATE:
  - mem_req = {addr={req tag, index, 4'b0}, rw=0, valid=1}.
  - Hold until mem_data.ready=1.
  - On the ready cycle:
    - data_req.we=1, data_write = mem_data.data.
    - tag_req.we=1, tag_write = {valid=1, dirty=0, tag=req tag}.
    - Go to COMPARE_TAG; the re-compare then hits, and a write merges in that cycle.
- Latency from cpu_req.valid sampled in IDLE:
  - Hit: ready 1 cycle later.
  - Clean miss: ready 2 + N cycles later, where N = cycles until mem ready.
  - Dirty miss: adds the write-back wait.
- CPU handshake:
  - valid is sampled only in IDLE.
  - The requester holds addr/data stable until ready, then must drop valid in the cycle after ready, or it is taken as a new request.
  - Best hit throughput is one request per 2 cycles.
- Memory handshake: valid and addr/data are held constant until ready; ready seen while in IDLE/COMPARE_TAG is ignored.
- Store writes take effect at the next posedge; reads are combinational, so COMPARE_TAG sees the refilled line.

Decomposition:
- Package cache_def holds:
  - Types: cpu_req_type, cpu_result_type, mem_req_type, mem_data_type, cache_req_type, cache_tag_type, cache_data_type.
  - Widths TAGMSB=31, TAGLSB=14.
  - State enum cache_state_type.
- Optional sub-module dm_cache_word_merge: combinational 128-bit word insert/select.

Test Plan:
- Read miss, cold cache, addr=0x0000_4010; mem ready after 3 cycles with data 0x4444_3333_2222_1111 (upper half 0):
  - mem_req {addr 0x4010, rw=0} is observed.
  - Then ready=1 with data 0x0000_1111, at latency 5.
  - Tag[1] = {1,0,0x1}.
- Read hit on same address, word 1 (addr 0x4014): ready 1 cycle after accept, data 0x0000_2222, no mem_req.valid.
- Write hit to 0x4018 with data 0xDEAD_BEEF:
  - Ready after 1 cycle, tag[1].dirty=1.
  - A following read of 0x4018 returns 0xDEAD_BEEF.
- Dirty conflict read of 0x8010:
  - Write-back request addr 0x4010, rw=1, data word2 = 0xDEAD_BEEF.
  - Then allocate request addr 0x8010, rw=0.
  - Final tag[1] = {1,0,0x2}.
- rst_n=0 during ALLOCATE wait:
  - Next cycle mem_req.valid=0, state IDLE, tag[1] unchanged.
  - A later request behaves as fresh.
- mem_data.ready pulsed while IDLE and cpu_req.valid held high after ready: no state change from the stray ready; the held valid is re-accepted as a new request.
